// File: rtl/branch_redirect_ctrl.sv
// Execute-stage redirect control: resolves branches/jumps into pcsrc and pipeline flushes,
// with a post-redirect shadow window. Optional branch statistics under `BRANCH_STATS_EN.
module branch_redirect_ctrl #(
    parameter int SHADOW_CYCLES = 1,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   trigger,
    input  logic                   stall,
    input  logic                   valide,
    input  logic                   branche,
    input  logic                   jumpe,
    input  logic                   jalre,
    input  logic [2:0]             funct3e,
    input  logic                   zeroe,
    input  logic                   lte,
    input  logic                   ltue,
    output logic [1:0]             pcsrc,
    output logic                   flushd,
    output logic                   flushe,
    output logic                   illegal_branch,
    output logic [COUNT_WIDTH-1:0] redirect_cnt,
    output logic [COUNT_WIDTH-1:0] branch_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SHADOW = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [1:0]             shadow_q, shadow_d;
    logic                   illegal_q, illegal_d;
    logic [COUNT_WIDTH-1:0] redirect_cnt_q, redirect_cnt_d;

    logic br_cond;
    logic br_illegal;
    logic eval;
    logic redirect;

    always_comb begin
        br_cond    = 1'b0;
        br_illegal = 1'b0;
        case (funct3e)
            3'b000:  br_cond = zeroe;
            3'b001:  br_cond = !zeroe;
            3'b100:  br_cond = lte;
            3'b101:  br_cond = !lte;
            3'b110:  br_cond = ltue;
            3'b111:  br_cond = !ltue;
            default: br_illegal = 1'b1;
        endcase
    end

    // Only instructions seen in RUN, unstalled and enabled, are resolved.
    assign eval     = trigger && (state_q == ST_RUN) && !stall && valide;
    assign redirect = eval && (jalre || jumpe || (branche && br_cond));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            shadow_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        if (!trigger) begin
            state_d  = ST_IDLE;
            shadow_d = 2'd0;
        end else if (!stall) begin
            case (state_q)
                ST_IDLE: state_d = ST_RUN;
                ST_RUN: begin
                    if (redirect) begin
                        state_d  = ST_SHADOW;
                        shadow_d = 2'(SHADOW_CYCLES);
                    end
                end
                ST_SHADOW: begin
                    shadow_d = (shadow_q == 2'd0) ? 2'd0 : shadow_q - 2'd1;
                    if (shadow_q <= 2'd1) state_d = ST_RUN;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        pcsrc  = 2'b00;
        flushd = 1'b0;
        flushe = 1'b0;
        if (!trigger || state_q == ST_IDLE) begin
            flushd = 1'b1;
            flushe = 1'b1;
        end else if (redirect) begin
            pcsrc  = jalre ? 2'b10 : 2'b01;
            flushd = 1'b1;
            flushe = 1'b1;
        end
    end

    always_comb begin
        redirect_cnt_d = redirect_cnt_q;
        if (redirect && (redirect_cnt_q != {COUNT_WIDTH{1'b1}}))
            redirect_cnt_d = redirect_cnt_q + 1'b1;
        illegal_d = illegal_q || (eval && branche && br_illegal);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_cnt_q <= '0;
            illegal_q      <= 1'b0;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
            illegal_q      <= illegal_d;
        end
    end

    assign redirect_cnt   = redirect_cnt_q;
    assign illegal_branch = illegal_q;

`ifdef BRANCH_STATS_EN
    logic [COUNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;

    always_comb begin
        branch_cnt_d = branch_cnt_q;
        if (eval && branche && (branch_cnt_q != {COUNT_WIDTH{1'b1}}))
            branch_cnt_d = branch_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) branch_cnt_q <= '0;
        else     branch_cnt_q <= branch_cnt_d;
    end

    assign branch_cnt = branch_cnt_q;
`else
    assign branch_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl with a cycle-level reference model and literal spot checks.
module tb_branch_redirect_ctrl;
    localparam int SH = 1;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst, trigger, stall, valide, branche, jumpe, jalre;
    logic [2:0]    funct3e;
    logic          zeroe, lte, ltue;
    logic [1:0]    pcsrc;
    logic          flushd, flushe, illegal_branch;
    logic [CW-1:0] redirect_cnt, branch_cnt;

    int n_cmp = 0;
    int n_err = 0;

    branch_redirect_ctrl #(.SHADOW_CYCLES(SH), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .trigger(trigger), .stall(stall), .valide(valide),
        .branche(branche), .jumpe(jumpe), .jalre(jalre), .funct3e(funct3e),
        .zeroe(zeroe), .lte(lte), .ltue(ltue), .pcsrc(pcsrc), .flushd(flushd),
        .flushe(flushe), .illegal_branch(illegal_branch),
        .redirect_cnt(redirect_cnt), .branch_cnt(branch_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: "active" means the core has started, shadow_left counts masked cycles.
    bit m_active = 0;
    int m_shadow = 0;
    int m_rcnt = 0;
    int m_bcnt = 0;
    bit m_ill = 0;

    function automatic bit taken(input int f3, input bit z, input bit lt, input bit ltu);
        case (f3)
            0: return z;
            1: return !z;
            4: return lt;
            5: return !lt;
            6: return ltu;
            7: return !ltu;
            default: return 0;
        endcase
    endfunction

    always @(negedge clk) begin
        int e_pc;
        bit e_fl, resolving, redir;
        if (rst) begin
            m_active = 0; m_shadow = 0; m_rcnt = 0; m_bcnt = 0; m_ill = 0;
            chk("m_rst_pcsrc", pcsrc, 0);
            chk("m_rst_flushd", flushd, 1);
            chk("m_rst_flushe", flushe, 1);
        end else begin
            resolving = trigger && m_active && m_shadow == 0 && !stall && valide;
            redir = resolving && (jalre || jumpe || (branche && taken(funct3e, zeroe, lte, ltue)));
            e_pc = 0; e_fl = 0;
            if (!trigger || !m_active) e_fl = 1;
            else if (redir) begin
                e_pc = jalre ? 2 : 1;
                e_fl = 1;
            end
            chk("m_pcsrc", pcsrc, e_pc);
            chk("m_flushd", flushd, e_fl);
            chk("m_flushe", flushe, e_fl);
        end
        chk("m_illegal", illegal_branch, m_ill);
        chk("m_redirect_cnt", redirect_cnt, m_rcnt);
        chk("m_branch_cnt", branch_cnt, m_bcnt);
        if (!rst) begin
            if (resolving && branche) begin
                if (funct3e == 2 || funct3e == 3) m_ill = 1;
`ifdef BRANCH_STATS_EN
                if (m_bcnt < CMAX) m_bcnt++;
`endif
            end
            if (redir && m_rcnt < CMAX) m_rcnt++;
            if (!trigger) begin
                m_active = 0; m_shadow = 0;
            end else if (!stall) begin
                if (!m_active) m_active = 1;
                else if (m_shadow > 0) m_shadow--;
                else if (redir) m_shadow = SH;
            end
        end
    end

    // Applies one cycle of inputs just after the edge, then waits for the sampling edge.
    task automatic step(input logic tr = 1, input logic st = 0, input logic v = 0,
                        input logic br = 0, input logic j = 0, input logic jr = 0,
                        input logic [2:0] f3 = 0, input logic z = 0, input logic lt = 0,
                        input logic ltu = 0, input logic r = 0);
        @(posedge clk);
        #1;
        trigger = tr; stall = st; valide = v; branche = br; jumpe = j; jalre = jr;
        funct3e = f3; zeroe = z; lte = lt; ltue = ltu; rst = r;
        @(negedge clk);
    endtask

    initial begin
        rst = 1; trigger = 1; stall = 0; valide = 0; branche = 0; jumpe = 0; jalre = 0;
        funct3e = 0; zeroe = 0; lte = 0; ltue = 0;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_pcsrc", pcsrc, 0);
        chk("rst_flushd", flushd, 1);
        step(1);
        step(1);
        chk("run_flushd", flushd, 0);
        chk("run_rcnt", redirect_cnt, 0);

        step(1, 0, 1, 1, 0, 0, 3'd0, 1);
        chk("beq_pcsrc", pcsrc, 1);
        chk("beq_flushe", flushe, 1);
        step(1, 0, 1, 1, 0, 0, 3'd0, 1);
        chk("shadow_pcsrc", pcsrc, 0);
        chk("shadow_flushd", flushd, 0);
        step(1, 0, 1, 1, 0, 0, 3'd0, 1);
        chk("beq2_pcsrc", pcsrc, 1);
        step(1);
        chk("rcnt_two", redirect_cnt, 2);

        step(1, 0, 1, 0, 1, 1);
        chk("jalr_prec", pcsrc, 2);
        step(1);
        step(1, 0, 1, 1, 0, 0, 3'd5, 0, 1);
        chk("bge_nt", pcsrc, 0);
        step(1);
        chk("rcnt_three", redirect_cnt, 3);

        step(1, 0, 1, 1, 0, 0, 3'd3);
        chk("illegal_pcsrc", pcsrc, 0);
        step(1);
        chk("illegal_set", illegal_branch, 1);

        repeat (3) step(1, 1, 1, 1, 0, 0, 3'd6, 0, 0, 1);
        chk("stall_pcsrc", pcsrc, 0);
        step(1, 0, 1, 1, 0, 0, 3'd6, 0, 0, 1);
        chk("unstall_pcsrc", pcsrc, 1);
        step(1);
        chk("rcnt_four", redirect_cnt, 4);
        chk("illegal_sticky", illegal_branch, 1);

        step(0, 1);
        chk("trig_fall_flushd", flushd, 1);
        step(1);
        chk("idle_flushe", flushe, 1);
        step(1);
        chk("rerun_flushd", flushd, 0);

        for (int i = 0; i < 40; i++) step(1, 0, 1, 0, 1);
        step(1);
        chk("rcnt_sat", redirect_cnt, CMAX);

        step(1, 0, 1, 0, 1);
        @(posedge clk);
        #1 rst = 1;
        #1;
        chk("rst_mid_pcsrc", pcsrc, 0);
        chk("rst_mid_flushd", flushd, 1);
        chk("rst_mid_rcnt", redirect_cnt, 0);
        chk("rst_mid_illegal", illegal_branch, 0);
        @(negedge clk);
        step(1);
        step(1);

        step(1, 0, 1, 1, 0, 0, 3'd0, 1);
        step(1);
        step(1, 0, 1, 1, 0, 0, 3'd1, 1);
        step(1, 0, 1, 1, 0, 0, 3'd4, 0, 1);
        step(1);
        step(1, 0, 1, 1, 0, 0, 3'd7, 0, 0, 1);
        step(1, 0, 1, 1, 0, 0, 3'd6, 0, 0, 1);
        step(1);
        step(1);
`ifdef BRANCH_STATS_EN
        chk("branch_cnt_five", branch_cnt, 5);
`else
        chk("branch_cnt_zero", branch_cnt, 0);
`endif
        chk("rcnt_after_stats", redirect_cnt, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Execute-stage control block that generates the 2-bit PC-source select consumed by the next-PC mux.
- Resolves RISC-V branches and jumps from the ALU flags and decoded execute-stage controls.
- Drives the decode and execute pipeline flushes.
- Runs a small FSM that idles while the core is not triggered and masks wrong-path instructions for a programmable shadow window after each redirect.

Parameters:
- SHADOW_CYCLES, 1: cycles after a redirect during which execute-stage branch/jump inputs are ignored (1..3).
- COUNT_WIDTH, 16: width of the statistics counters.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous, active-high reset
- trigger  input  1  run enable; 0 holds core at PC 0
- stall  input  1  pipeline hold; freezes the FSM
- valide  input  1  execute stage holds a real instruction
- branche  input  1  execute instruction is a conditional branch
- jumpe  input  1  execute instruction is jal
- jalre  input  1  execute instruction is jalr
- funct3e  input  3  branch condition code
- zeroe  input  1  ALU result == 0
- lte  input  1  signed rs1 < rs2
- ltue  input  1  unsigned rs1 < rs2
- pcsrc  output  2  00 = pc+4, 01 = pce+immexte (branch/jal), 10 = aluresult (jalr); 11 is never driven
- flushd  output  1  clear IF/ID register
- flushe  output  1  clear ID/EX register
- illegal_branch  output  1  sticky: a branch with funct3 010/011 was seen
- redirect_cnt  output  COUNT_WIDTH  redirects taken, saturating
- branch_cnt  output  COUNT_WIDTH  conditional branches resolved (optional feature)

Behaviour:
- Reset (asynchronous): state=IDLE, shadow counter=0, redirect_cnt=0, branch_cnt=0, illegal_branch=0. Combinational outputs during reset: pcsrc=00, flushd=1, flushe=1.
- States: IDLE, RUN, SHADOW.
- IDLE:
  - pcsrc=00, flushd=flushe=1.
  - trigger=1 moves to RUN on the next edge.
- Any state, trigger=0:
  - Combinationally pcsrc=00, flushd=flushe=1.
  - Next state is IDLE; shadow counter is cleared.
- Branch condition by funct3e:
  - 000 beq → zeroe
  - 001 bne → !zeroe
  - 100 blt → lte
  - 101 bge → !lte
  - 110 bltu → ltue
  - 111 bgeu → !ltue
  - 010/011 → not taken, sets illegal_branch on the edge.
- Redirect condition: RUN && !stall && valide && (jalre || jumpe || (branche && cond)).
- Precedence: jalre > jumpe > branche.
- pcsrc encoding: 10 for jalr, 01 for jal or a taken branch, else 00.
- On redirect (all combinational, same cycle zero latency): pcsrc as above, flushd=flushe=1.
- On redirect (registered): redirect_cnt +1, saturating at all-ones; shadow counter loaded with SHADOW_CYCLES; next state is SHADOW.
- No redirect in RUN: pcsrc=00, flushes 0.
- SHADOW:
  - Branch/jump inputs are ignored; pcsrc=00, flushes 0.
  - Counter decrements each non-stalled cycle; leaves for RUN on the edge where it reaches 0.
  - A real branch arriving in the cycle after the exit edge is evaluated normally.
- stall=1:
  - No state change, no counter change, pcsrc=00, flushes 0.
  - A taken branch held in execute redirects in the first cycle stall drops.
- Simultaneous stall and trigger fall: trigger has priority, giving IDLE.
- Reset mid-SHADOW: immediate IDLE; counters cleared.
- branch_cnt increments for every evaluated branche && valide in RUN with !stall, taken or not; saturating.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined: branch_cnt implemented as above.
- Undefined: branch_cnt tied to 0 with no counter logic; port list unchanged.

Test Plan:
- Reset asserted mid-cycle, trigger=1 → pcsrc=00 and flushd=flushe=1 immediately; one edge after release, state=RUN and redirect_cnt=0.
- RUN, valide=1, branche=1, funct3e=000, zeroe=1 → same cycle pcsrc=01, flushd=flushe=1. Next cycle (SHADOW_CYCLES=1), branche=1/zeroe=1 is ignored (pcsrc=00). The cycle after that, a branch redirects again. redirect_cnt=2.
- jalre=1 and jumpe=1 together → pcsrc=10. With funct3e=101, lte=1, branche=1 only → pcsrc=00, redirect_cnt unchanged.
- branche=1, funct3e=011 → pcsrc=00, illegal_branch=1 and remains 1 until reset.
- stall=1 with taken bltu (ltue=1) held 3 cycles → pcsrc=00 during stall; first cycle after stall drops → pcsrc=01, redirect_cnt+1.
- redirect_cnt preset near max via 2^COUNT_WIDTH+2 jal redirects (COUNT_WIDTH=4) → saturates at 15. With BRANCH_STATS_EN, 5 branches (3 taken) → branch_cnt=5. Without the macro → branch_cnt=0.
